// File: rtl/spi_reg_bank.sv
// Configuration register bank fed by completed SPI transactions. Enable registers
// update immediately; the PWM duty cycle is double-buffered and committed at period wrap.
module spi_reg_bank #(
  parameter int unsigned MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic       read_write,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  input  logic       period_start,
  input  logic       err_clr,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       pending,
  output logic       err_addr,
  output logic       err_read,
  output logic [7:0] wr_count
);

  localparam logic [6:0] MaxAddr  = 7'(MAX_ADDR);
  localparam logic [6:0] DutyAddr = 7'd4;

  logic       valid_q;
  logic [7:0] en_q [4];
  logic [7:0] en_d [4];
  logic [7:0] duty_q, duty_d;
  logic [7:0] shadow_q, shadow_d;
  logic       pending_q, pending_d;
  logic       err_addr_q, err_addr_d;
  logic       err_read_q, err_read_d;
  logic [7:0] wr_count_q, wr_count_d;

  logic accept, wr_acc, wr_bad, rd_seen, wr_duty;

  always_comb begin
    accept  = valid & ~valid_q;
    wr_acc  = accept & read_write & (addr <= MaxAddr);
    wr_bad  = accept & read_write & (addr > MaxAddr);
    rd_seen = accept & ~read_write;
    wr_duty = wr_acc & (addr == DutyAddr);

    en_d       = en_q;
    duty_d     = duty_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    wr_count_d = wr_count_q;

    if (wr_acc && (addr < 7'd4)) begin
      en_d[addr[1:0]] = data;
    end

    // A duty write landing on the period boundary bypasses the shadow wait.
    if (wr_duty && period_start) begin
      duty_d    = data;
      shadow_d  = data;
      pending_d = 1'b0;
    end else if (wr_duty) begin
      shadow_d  = data;
      pending_d = 1'b1;
    end else if (period_start && pending_q) begin
      duty_d    = shadow_q;
      pending_d = 1'b0;
    end

    if (wr_acc) begin
      wr_count_d = wr_count_q + 8'd1;
    end

    err_addr_d = (err_addr_q & ~err_clr) | wr_bad;
    err_read_d = (err_read_q & ~err_clr) | rd_seen;
  end

  // valid_q resets high so a level already asserted at reset release is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b1;
      en_q       <= '{default: '0};
      duty_q     <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      err_addr_q <= 1'b0;
      err_read_q <= 1'b0;
      wr_count_q <= '0;
    end else begin
      valid_q    <= valid;
      en_q       <= en_d;
      duty_q     <= duty_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      err_addr_q <= err_addr_d;
      err_read_q <= err_read_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign en_reg_out_7_0  = en_q[0];
  assign en_reg_out_15_8 = en_q[1];
  assign en_reg_pwm_7_0  = en_q[2];
  assign en_reg_pwm_15_8 = en_q[3];
  assign pwm_duty_cycle  = duty_q;
  assign pending         = pending_q;
  assign err_addr        = err_addr_q;
  assign err_read        = err_read_q;
  assign wr_count        = wr_count_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: a transaction-level model pushes expected output
// snapshots to a queue when stimulus is driven; they are popped and checked after the edge.
module tb_spi_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic       read_write;
  logic [6:0] addr;
  logic [7:0] data;
  logic       period_start;
  logic       err_clr;
  logic [7:0] en0, en1, en2, en3, duty, cnt;
  logic       pend, ea, er;

  always #5 clk = ~clk;

  spi_reg_bank #(.MAX_ADDR(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid          (valid),
    .read_write     (read_write),
    .addr           (addr),
    .data           (data),
    .period_start   (period_start),
    .err_clr        (err_clr),
    .en_reg_out_7_0 (en0),
    .en_reg_out_15_8(en1),
    .en_reg_pwm_7_0 (en2),
    .en_reg_pwm_15_8(en3),
    .pwm_duty_cycle (duty),
    .pending        (pend),
    .err_addr       (ea),
    .err_read       (er),
    .wr_count       (cnt)
  );

  typedef logic [50:0] snap_t;
  typedef struct {
    string tag;
    snap_t val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Model state
  logic [7:0] m_en [4];
  logic [7:0] m_duty, m_shadow, m_cnt;
  logic       m_pend, m_ea, m_er;

  function automatic snap_t dut_snap();
    return {en0, en1, en2, en3, duty, pend, ea, er, cnt};
  endfunction

  function automatic snap_t model_snap();
    return {m_en[0], m_en[1], m_en[2], m_en[3], m_duty, m_pend, m_ea, m_er, m_cnt};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_en[i] = 8'h00;
    m_duty = 8'h00; m_shadow = 8'h00; m_cnt = 8'h00;
    m_pend = 1'b0;  m_ea = 1'b0;      m_er = 1'b0;
  endtask

  // One clock of effect: acc=1 means a new transaction is accepted this edge.
  task automatic model_edge(input logic acc, input logic rw, input logic [6:0] a,
                            input logic [7:0] d, input logic ps, input logic clr);
    logic duty_wr;
    duty_wr = acc && rw && (a == 7'd4);
    if (acc && rw && a < 7'd4) m_en[a[1:0]] = d;
    if (duty_wr && ps) begin
      m_duty = d; m_shadow = d; m_pend = 1'b0;
    end else if (duty_wr) begin
      m_shadow = d; m_pend = 1'b1;
    end else if (ps && m_pend) begin
      m_duty = m_shadow; m_pend = 1'b0;
    end
    if (acc && rw && a <= 7'd4) m_cnt = m_cnt + 8'd1;
    if (clr) begin
      m_ea = 1'b0; m_er = 1'b0;
    end
    if (acc && rw && a > 7'd4) m_ea = 1'b1;
    if (acc && !rw) m_er = 1'b1;
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.val = model_snap();
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t  e;
    snap_t obs;
    obs = dut_snap();
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: valid high one cycle (checked), then low one cycle.
  task automatic xact(input string tag, input logic rw, input logic [6:0] a,
                      input logic [7:0] d, input logic ps, input logic clr);
    valid = 1'b1; read_write = rw; addr = a; data = d;
    period_start = ps; err_clr = clr;
    model_edge(1'b1, rw, a, d, ps, clr);
    push_exp(tag);
    step();
    check_pop();
    valid = 1'b0; period_start = 1'b0; err_clr = 1'b0;
    step();
  endtask

  // Strobe-only cycle (no transaction).
  task automatic strobe(input string tag, input logic ps, input logic clr);
    period_start = ps; err_clr = clr;
    model_edge(1'b0, 1'b0, 7'd0, 8'd0, ps, clr);
    push_exp(tag);
    step();
    check_pop();
    period_start = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; read_write = 1'b0; addr = '0; data = '0;
    period_start = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    push_exp("reset_state");
    step();
    check_pop();

    xact("wr_en0_a5", 1'b1, 7'h00, 8'hA5, 1'b0, 1'b0);
    xact("wr_en1_3c", 1'b1, 7'h01, 8'h3C, 1'b0, 1'b0);
    xact("wr_en2_ff", 1'b1, 7'h02, 8'hFF, 1'b0, 1'b0);
    xact("wr_en3_01", 1'b1, 7'h03, 8'h01, 1'b0, 1'b0);

    // Valid held high for 50 cycles: only the first edge accepts.
    valid = 1'b1; read_write = 1'b1; addr = 7'h00; data = 8'h11;
    for (int i = 0; i < 50; i++) begin
      model_edge(i == 0, 1'b1, 7'h00, 8'h11, 1'b0, 1'b0);
      push_exp($sformatf("hold_valid_%0d", i));
      step();
      if (i == 0 || i == 49) check_pop();
      else void'(sb.pop_back());
    end
    valid = 1'b0;
    step();

    xact("duty_shadow_80", 1'b1, 7'h04, 8'h80, 1'b0, 1'b0);
    xact("duty_shadow_40", 1'b1, 7'h04, 8'h40, 1'b0, 1'b0);
    strobe("duty_commit_40", 1'b1, 1'b0);
    strobe("commit_no_pending", 1'b1, 1'b0);
    xact("duty_same_cycle_20", 1'b1, 7'h04, 8'h20, 1'b1, 1'b0);

    xact("err_addr_05", 1'b1, 7'h05, 8'h99, 1'b0, 1'b0);
    xact("err_read_00", 1'b0, 7'h00, 8'h77, 1'b0, 1'b0);
    strobe("err_clr", 1'b0, 1'b1);
    xact("err_clr_vs_7f", 1'b1, 7'h7F, 8'hEE, 1'b0, 1'b1);

    // Reset with valid held high through release: no transaction.
    valid = 1'b1; read_write = 1'b1; addr = 7'h00; data = 8'h55;
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    push_exp("valid_high_thru_reset");
    step();
    check_pop();
    valid = 1'b0;
    push_exp("valid_fall_after_reset");
    step();
    check_pop();

    // 256 accepted writes wrap the counter; the last one leaves a pending shadow.
    for (int i = 0; i < 256; i++) begin
      xact($sformatf("wrap_wr_%0d", i), 1'b1, (i == 255) ? 7'h04 : 7'(i % 4),
           8'(i), 1'b0, 1'b0);
    end

    // Asynchronous reset mid-operation, checked before any further clock edge.
    rst_n = 1'b0;
    model_reset();
    push_exp("async_reset_pending");
    #2;
    check_pop();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
